// File: rtl/fu_sequencer.sv
// fu_sequencer: walks the operand ROM and drives the 8-bit function unit.
// Each operand pair is run with a fixed function select or a 0..15 sweep.
// Every result is captured with its V/C/N/Z flags and an address/FS tag.
// Results are handed out over a valid/ready port.
module fu_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              sweep,
  input  logic [3:0]        fs_sel,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        fu_opa,
  output logic [7:0]        fu_opb,
  output logic [3:0]        fu_fs,
  input  logic [7:0]        fu_result,
  input  logic              fu_v,
  input  logic              fu_c,
  input  logic              fu_n,
  input  logic              fu_z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data,
  output logic [3:0]        res_flags,
  output logic [ADDR_W-1:0] res_addr,
  output logic [3:0]        res_fs,
  output logic [3:0]        flag_acc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_EXEC    = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              sweep_r;
  logic [3:0]        fs_fix_r;
  logic [ADDR_W-1:0] last_r;
  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic              valid_nxt_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision; abort from any active state overrides everything else.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_FETCH;
        else       state_nxt_s = S_IDLE;
      end
      S_FETCH:   state_nxt_s = S_LOAD;
      S_LOAD:    state_nxt_s = S_EXEC;
      S_EXEC:    state_nxt_s = S_PRESENT;
      S_PRESENT: begin
        if (!res_ready)                     state_nxt_s = S_PRESENT;
        else if (sweep_r && fu_fs != 4'hF)  state_nxt_s = S_EXEC;
        else if (rom_addr != last_r)        state_nxt_s = S_FETCH;
        else                                state_nxt_s = S_DONE;
      end
      S_DONE:    state_nxt_s = S_IDLE;
      default:   state_nxt_s = S_IDLE;
    endcase
    if (abort && state_r != S_IDLE) state_nxt_s = S_IDLE;
    else                            state_nxt_s = state_nxt_s;
  end

  // Status outputs for the upcoming state, registered below so they align with it.
  always_comb begin
    busy_nxt_s  = (state_nxt_s != S_IDLE);
    done_nxt_s  = (state_nxt_s == S_DONE);
    valid_nxt_s = (state_nxt_s == S_PRESENT);
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      busy      <= busy_nxt_s;
      done      <= done_nxt_s;
      res_valid <= valid_nxt_s;
    end
  end

  // Run configuration, ROM address, operand/FS drive, result capture and flag accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sweep_r   <= 1'b0;
      fs_fix_r  <= 4'd0;
      last_r    <= {ADDR_W{1'b0}};
      rom_addr  <= {ADDR_W{1'b0}};
      fu_opa    <= 8'd0;
      fu_opb    <= 8'd0;
      fu_fs     <= 4'd0;
      res_data  <= 8'd0;
      res_flags <= 4'd0;
      res_addr  <= {ADDR_W{1'b0}};
      res_fs    <= 4'd0;
      flag_acc  <= 4'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            sweep_r  <= sweep;
            fs_fix_r <= fs_sel;
            last_r   <= last_addr;
            rom_addr <= {ADDR_W{1'b0}};
            flag_acc <= 4'd0;
            fu_fs    <= sweep ? 4'd0 : fs_sel;
          end
        end
        S_LOAD: begin
          if (!abort) begin
            fu_opa <= rom_data[15:8];
            fu_opb <= rom_data[7:0];
          end
        end
        S_EXEC: begin
          if (!abort) begin
            res_data  <= fu_result;
            res_flags <= {fu_v, fu_c, fu_n, fu_z};
            res_addr  <= rom_addr;
            res_fs    <= fu_fs;
          end
        end
        S_PRESENT: begin
          if (!abort && res_ready) begin
            flag_acc <= flag_acc | res_flags;
            if (state_nxt_s == S_EXEC) begin
              fu_fs <= fu_fs + 4'd1;
            end else if (state_nxt_s == S_FETCH) begin
              rom_addr <= rom_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              fu_fs    <= sweep_r ? 4'd0 : fs_fix_r;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
